// File: rtl/decim_comb_pkg.sv
// Shared constants and helpers for the decimating comb stage.
// The saturation limits here are the same values the accumulator uses for its SAT_HIGH/LOW.
package decim_comb_pkg;
  localparam int LIM_W = 64;

  typedef struct packed {
    logic signed [LIM_W-1:0] hi;
    logic signed [LIM_W-1:0] lo;
  } sat_lim_t;

  function automatic sat_lim_t sat_limits(input int width);
    sat_lim_t l;
    l.hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    l.lo = -(64'sd1 <<< (width - 1));
    return l;
  endfunction
endpackage

// File: rtl/decim_comb_if.sv
// Stream bus around the comb stage: sample input side and saturated output side.
interface decim_comb_if #(
  parameter int ACCUM_SZ = 32,
  parameter int DATA_SZ  = 16
) ();
  logic                in_valid;
  logic                in_ready;
  logic [ACCUM_SZ-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_SZ-1:0]  out_data;
  logic                out_sat;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_sat);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/decim_comb_sat_narrow.sv
// Signed narrowing with clip flag: IN_W two's-complement value clamped into OUT_W bits.
module sat_narrow
  import decim_comb_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clip
);
  localparam sat_lim_t LIM = sat_limits(OUT_W);

  logic signed [LIM_W-1:0] dx;

  always_comb begin
    dx   = LIM_W'(signed'(din));
    dout = din[OUT_W-1:0];
    clip = 1'b0;
    if (dx > $signed(LIM.hi)) begin
      dout = LIM.hi[OUT_W-1:0];
      clip = 1'b1;
    end else if (dx < $signed(LIM.lo)) begin
      dout = LIM.lo[OUT_W-1:0];
      clip = 1'b1;
    end
  end
endmodule

// File: rtl/decim_comb.sv
// Decimate-by-DECIM then first difference of kept samples (CIC comb, M=1), saturated output.
module decim_comb
  import decim_comb_pkg::*;
#(
  parameter int ACCUM_SZ = 32,
  parameter int DATA_SZ  = 16,
  parameter int DECIM    = 4
) (
  input  logic         clk,
  input  logic         reset,
  decim_comb_if.slave  bus
);
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0]    dec_cnt;
  logic                primed;
  logic [ACCUM_SZ-1:0] prev_kept;
  logic [ACCUM_SZ-1:0] diff;
  logic [DATA_SZ-1:0]  sat_data;
  logic                sat_clip;
  logic                keep_slot, acc, kept, push;

  // Only the kept slot can stall; it needs room in the output register.
  assign keep_slot    = (dec_cnt == LAST);
  assign bus.in_ready = reset || !keep_slot || !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  assign kept         = acc && keep_slot;
  assign push         = kept && primed;
  assign diff         = bus.in_data - prev_kept;

  sat_narrow #(.IN_W(ACCUM_SZ), .OUT_W(DATA_SZ)) u_sat (
    .din  (diff),
    .dout (sat_data),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_cnt       <= '0;
      primed        <= 1'b0;
      prev_kept     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      if (acc)
        dec_cnt <= keep_slot ? '0 : dec_cnt + CNT_W'(1);
      if (kept) begin
        prev_kept <= bus.in_data;
        primed    <= 1'b1;
      end
      // A push on the same edge as a pop overwrites without a bubble.
      if (push) begin
        bus.out_data  <= sat_data;
        bus.out_sat   <= sat_clip;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
